// File: rtl/go_clock_pkg.sv
// Shared definitions for the Go game clock: control FSM states and
// width helpers used to size the per-player buses.
package go_clock_pkg;

  // Control FSM states of the game clock.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } clock_state_e;

  // Bits needed to encode n distinct values, never less than one bit.
  function automatic int width_of(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Width of a byo-yomi period counter able to hold 0..periods.
  function automatic int per_width(input int periods);
    return width_of(periods + 1);
  endfunction

endpackage

// File: rtl/go_clock_channel.sv
// One player's clock: main time, byo-yomi overtime and the sticky
// timeout flag. The top level decides when this channel counts.
module go_clock_channel
  import go_clock_pkg::*;
#(
  parameter int MAIN_SEC    = 1800,
  parameter int BYO_SEC     = 30,
  parameter int BYO_PERIODS = 3,
  parameter int SEC_W       = 12,
  parameter int PER_W       = per_width(BYO_PERIODS)
) (
  input  logic             clk_2Hz,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             dec,
  input  logic             byo_reload,
  output logic [SEC_W-1:0] time_left,
  output logic [PER_W-1:0] periods_left,
  output logic             in_byo,
  output logic             timeout,
  output logic             expire
);

  localparam logic [SEC_W-1:0] MAIN_LOAD = SEC_W'(MAIN_SEC);
  localparam logic [SEC_W-1:0] BYO_LOAD  = SEC_W'(BYO_SEC);
  localparam logic [PER_W-1:0] PER_LOAD  = PER_W'(BYO_PERIODS);
  localparam logic             HAS_BYO   = (BYO_PERIODS > 0);

  // Flags that the next decrement would run this player out of time.
  always_comb begin
    expire = 1'b0;
    if (time_left <= SEC_W'(1)) begin
      if (!in_byo && HAS_BYO) begin
        expire = 1'b0;
      end else if (in_byo && (periods_left > PER_W'(1))) begin
        expire = 1'b0;
      end else begin
        expire = 1'b1;
      end
    end else begin
      expire = 1'b0;
    end
  end

  // Time bookkeeping: reload, one-second decrement, overtime entry and
  // period hand-over, and the reload of a byo-yomi period after a move.
  always_ff @(posedge clk_2Hz or negedge rst_n) begin
    if (!rst_n) begin
      time_left    <= MAIN_LOAD;
      periods_left <= PER_LOAD;
      in_byo       <= 1'b0;
      timeout      <= 1'b0;
    end else if (clear) begin
      time_left    <= MAIN_LOAD;
      periods_left <= PER_LOAD;
      in_byo       <= 1'b0;
      timeout      <= 1'b0;
    end else if (dec) begin
      if (time_left > SEC_W'(1)) begin
        time_left <= time_left - SEC_W'(1);
      end else if (!in_byo && HAS_BYO) begin
        // Entering overtime: the period counter already counts this period.
        in_byo    <= 1'b1;
        time_left <= BYO_LOAD;
      end else if (in_byo && (periods_left > PER_W'(1))) begin
        periods_left <= periods_left - PER_W'(1);
        time_left    <= BYO_LOAD;
      end else begin
        time_left <= {SEC_W{1'b0}};
        timeout   <= 1'b1;
      end
    end else if (byo_reload && in_byo) begin
      time_left <= BYO_LOAD;
    end else begin
      time_left <= time_left;
    end
  end

endmodule

// File: rtl/go_clock_timer.sv
// Multi-player Go clock with byo-yomi, run from a 2 Hz tick. Holds the
// control FSM, the half-second phase, the turn pointer and the 1 s tick.
module go_clock_timer
  import go_clock_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int MAIN_SEC    = 1800,
  parameter int BYO_SEC     = 30,
  parameter int BYO_PERIODS = 3,
  parameter int SEC_W       = 12,
  parameter int PER_W       = per_width(BYO_PERIODS)
) (
  input  logic                         clk_2Hz,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         move_done,
  input  logic                         clear,
  output logic [$clog2(N_PLAYERS)-1:0] active,
  output logic [N_PLAYERS*SEC_W-1:0]   time_left,
  output logic [N_PLAYERS*PER_W-1:0]   periods_left,
  output logic [N_PLAYERS-1:0]         in_byo,
  output logic [N_PLAYERS-1:0]         timeout,
  output logic                         running,
  output logic                         tick_1s
);

  localparam int ACT_W = $clog2(N_PLAYERS);

  clock_state_e         state;
  logic                 half;
  logic                 do_dec;
  logic                 do_move;
  logic [N_PLAYERS-1:0] dec;
  logic [N_PLAYERS-1:0] byo_reload;
  logic [N_PLAYERS-1:0] expire;

  // Per-channel strobes: a move outranks pause, which outranks counting.
  always_comb begin
    do_move    = 1'b0;
    do_dec     = 1'b0;
    dec        = '0;
    byo_reload = '0;
    if ((state == RUN) && !clear) begin
      do_move = move_done;
      do_dec  = half && !move_done && !pause;
    end else begin
      do_move = 1'b0;
      do_dec  = 1'b0;
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      dec[i]        = do_dec  && (active == ACT_W'(i));
      byo_reload[i] = do_move && (active == ACT_W'(i));
    end
  end

  // Control FSM with registered running, half, active and tick_1s.
  always_ff @(posedge clk_2Hz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      active  <= '0;
      half    <= 1'b0;
      running <= 1'b0;
      tick_1s <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      active  <= '0;
      half    <= 1'b0;
      running <= 1'b0;
      tick_1s <= 1'b0;
    end else begin
      tick_1s <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (move_done) begin
            // Turn passes; the new player starts a fresh second.
            active <= (active == ACT_W'(N_PLAYERS - 1)) ? '0 : active + ACT_W'(1);
            half   <= 1'b0;
          end else if (pause) begin
            // Freeze with the phase intact so a resume continues the second.
            state   <= PAUSED;
            running <= 1'b0;
          end else if (half) begin
            half    <= 1'b0;
            tick_1s <= 1'b1;
            if (expire[active]) begin
              state   <= EXPIRED;
              running <= 1'b0;
            end
          end else begin
            half <= 1'b1;
          end
        end
        PAUSED: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        EXPIRED: begin
          state   <= EXPIRED;
          running <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // One timekeeping channel per player, flattened onto the output buses.
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_ch
    go_clock_channel #(
      .MAIN_SEC   (MAIN_SEC),
      .BYO_SEC    (BYO_SEC),
      .BYO_PERIODS(BYO_PERIODS),
      .SEC_W      (SEC_W),
      .PER_W      (PER_W)
    ) u_channel (
      .clk_2Hz     (clk_2Hz),
      .rst_n       (rst_n),
      .clear       (clear),
      .dec         (dec[g]),
      .byo_reload  (byo_reload[g]),
      .time_left   (time_left[g*SEC_W +: SEC_W]),
      .periods_left(periods_left[g*PER_W +: PER_W]),
      .in_byo      (in_byo[g]),
      .timeout     (timeout[g]),
      .expire      (expire[g])
    );
  end

endmodule

// File: tb/tb_go_clock_timer.sv
// Bench for go_clock_timer: reset values, a directed vector table walking
// main time, overtime, moves, timeout, clear and pause/resume, a mid-game
// reset, and a random run against a game-rule reference model.
module tb_go_clock_timer;

  localparam int N     = 2;
  localparam int MAIN  = 3;
  localparam int BYO   = 2;
  localparam int PER   = 2;
  localparam int SEC_W = 12;
  localparam int PER_W = 2;

  logic               clk_2Hz = 1'b0;
  logic               rst_n;
  logic               start, pause, move_done, clear;
  logic [0:0]         active;
  logic [N*SEC_W-1:0] time_left;
  logic [N*PER_W-1:0] periods_left;
  logic [N-1:0]       in_byo, timeout;
  logic               running, tick_1s;

  go_clock_timer #(
    .N_PLAYERS(N), .MAIN_SEC(MAIN), .BYO_SEC(BYO), .BYO_PERIODS(PER), .SEC_W(SEC_W)
  ) dut (
    .clk_2Hz(clk_2Hz), .rst_n(rst_n), .start(start), .pause(pause),
    .move_done(move_done), .clear(clear), .active(active), .time_left(time_left),
    .periods_left(periods_left), .in_byo(in_byo), .timeout(timeout),
    .running(running), .tick_1s(tick_1s)
  );

  always #5 clk_2Hz = ~clk_2Hz;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: apply pulses, wait for the edge, sample 1 time unit later.
  task automatic cycle(input bit s, input bit p, input bit m, input bit c);
    start = s; pause = p; move_done = m; clear = c;
    @(posedge clk_2Hz);
    #1;
    start = 1'b0; pause = 1'b0; move_done = 1'b0; clear = 1'b0;
  endtask

  typedef struct {
    bit s, p, m, c;
    int act, t0, t1, p0, byo0, to0, run, tick;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit p, bit m, bit c, int act, int t0, int t1,
                              int p0, int byo0, int to0, int run, int tick);
    vec_t v;
    v.s = s; v.p = p; v.m = m; v.c = c;
    v.act = act; v.t0 = t0; v.t1 = t1; v.p0 = p0;
    v.byo0 = byo0; v.to0 = to0; v.run = run; v.tick = tick;
    return v;
  endfunction

  // Reference model: game rules on plain integers.
  int m_mode;  // 0 idle, 1 running, 2 paused, 3 lost on time
  int m_phase, m_act;
  int m_t[N], m_p[N];
  bit m_b[N], m_o[N];
  bit m_tick;

  function automatic void model_reload();
    m_mode = 0; m_phase = 0; m_act = 0; m_tick = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_t[i] = MAIN; m_p[i] = PER; m_b[i] = 1'b0; m_o[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(bit s, bit p, bit m, bit c);
    m_tick = 1'b0;
    if (c) begin
      model_reload();
    end else if (m_mode == 1) begin
      if (m) begin
        if (m_b[m_act]) m_t[m_act] = BYO;
        m_act = (m_act + 1) % N;
        m_phase = 0;
      end else if (p) begin
        m_mode = 2;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else begin
        // A full second of the mover's time has elapsed.
        m_phase = 0;
        m_tick = 1'b1;
        if (m_t[m_act] > 1) begin
          m_t[m_act]--;
        end else if (!m_b[m_act] && PER > 0) begin
          m_b[m_act] = 1'b1; m_t[m_act] = BYO;
        end else if (m_b[m_act] && m_p[m_act] > 1) begin
          m_p[m_act]--; m_t[m_act] = BYO;
        end else begin
          m_t[m_act] = 0; m_o[m_act] = 1'b1; m_mode = 3;
        end
      end
    end else if ((m_mode == 0 || m_mode == 2) && s) begin
      m_mode = 1;
    end
  endfunction

  function automatic logic [63:0] pack(int act, int t0, int t1, int p0, int p1,
                                       bit b0, bit b1, bit o0, bit o1, bit run, bit tick);
    logic [63:0] r;
    r = '0;
    r[51:44] = act[7:0];
    r[43:32] = t0[11:0];
    r[31:20] = t1[11:0];
    r[19:16] = p0[3:0];
    r[15:12] = p1[3:0];
    r[11:0]  = {4'd0, b0, b1, o0, o1, 2'd0, run, tick};
    return r;
  endfunction

  initial begin
    logic [63:0] exp_v, act_v;
    int r;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; move_done = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk_2Hz);
    #1;
    chk("reset.active", 32'(active), 32'd0);
    chk("reset.t0", 32'(time_left[SEC_W-1:0]), 32'(MAIN));
    chk("reset.t1", 32'(time_left[2*SEC_W-1:SEC_W]), 32'(MAIN));
    chk("reset.p0", 32'(periods_left[PER_W-1:0]), 32'(PER));
    chk("reset.flags", 32'({in_byo, timeout, running, tick_1s}), 32'd0);
    @(negedge clk_2Hz);
    rst_n = 1'b1;
    @(posedge clk_2Hz);
    #1;

    //                s  p  m  c  act t0 t1 p0 by to run tick
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 3, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 3, 2, 1, 0, 1, 1));  // enter overtime
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 3, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 3, 2, 1, 0, 1, 0));  // move reloads byo
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 3, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 2, 2, 1, 0, 1, 1));  // p1 first dec at +2
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 2, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 2, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 2, 2, 1, 0, 1, 0));  // move on decrement edge
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 2, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 1, 2, 1, 0, 1, 0));  // p1 not in byo: keeps 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 1, 1, 0, 1, 1));  // next period
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 1, 1, 1, 0, 1, 0));  // move beats the flag
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1));  // timeout
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));  // start ignored
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0));  // move ignored
    tbl.push_back(mk(0, 0, 0, 1, 0, 3, 3, 2, 0, 0, 0, 0));  // clear
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 3, 2, 0, 0, 0, 0));  // pause with half=1
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 3, 2, 0, 0, 1, 0));  // resume
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 3, 2, 0, 0, 1, 1));  // lands 1 cycle later

    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].p, tbl[i].m, tbl[i].c);
      chk($sformatf("row%0d.active", i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("row%0d.t0", i), 32'(time_left[SEC_W-1:0]), 32'(tbl[i].t0));
      chk($sformatf("row%0d.t1", i), 32'(time_left[2*SEC_W-1:SEC_W]), 32'(tbl[i].t1));
      chk($sformatf("row%0d.p0", i), 32'(periods_left[PER_W-1:0]), 32'(tbl[i].p0));
      chk($sformatf("row%0d.in_byo0", i), 32'(in_byo[0]), 32'(tbl[i].byo0));
      chk($sformatf("row%0d.timeout0", i), 32'(timeout[0]), 32'(tbl[i].to0));
      chk($sformatf("row%0d.running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("row%0d.tick", i), 32'(tick_1s), 32'(tbl[i].tick));
    end

    // Asynchronous reset mid-RUN, with player 1 active.
    cycle(0, 0, 1, 0);
    chk("prereset.active", 32'(active), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("asyncrst.active", 32'(active), 32'd0);
    chk("asyncrst.running", 32'(running), 32'd0);
    chk("asyncrst.t0", 32'(time_left[SEC_W-1:0]), 32'(MAIN));
    chk("asyncrst.p0", 32'(periods_left[PER_W-1:0]), 32'(PER));
    @(posedge clk_2Hz);
    #2;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    chk("postrst.idle", 32'({running, tick_1s, time_left[SEC_W-1:0]}), 32'(MAIN));

    // Random pulses against the reference model.
    model_reload();
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 400; k++) begin
      bit s, p, m, c;
      r = $urandom_range(0, 99);
      s = 1'b0; p = 1'b0; m = 1'b0; c = 1'b0;
      if (r < 3) c = 1'b1;
      else if (r < 11) m = 1'b1;
      else if (r < 15) p = 1'b1;
      else if (r < 25) s = 1'b1;
      model_step(s, p, m, c);
      cycle(s, p, m, c);
      exp_v = pack(m_act, m_t[0], m_t[1], m_p[0], m_p[1], m_b[0], m_b[1],
                   m_o[0], m_o[1], (m_mode == 1), m_tick);
      act_v = pack(int'(active), int'(time_left[SEC_W-1:0]), int'(time_left[2*SEC_W-1:SEC_W]),
                   int'(periods_left[PER_W-1:0]), int'(periods_left[2*PER_W-1:PER_W]),
                   in_byo[0], in_byo[1], timeout[0], timeout[1], running, tick_1s);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rand%0d actual=%h expected=%h", k, act_v, exp_v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
